dmem_write_buffer: RTL and testbench

- Data-memory subsystem that connects directly to the CPU core's data-memory port: it consumes dm_write_* and dm_read_address, and produces dm_read_data.
- Stores go into a small FIFO write buffer and drain into an internal word array at a throttled rate, modelling slow backing memory.
- Loads see the newest buffered data through store-to-load forwarding.
- dm_stall tells the core to hold a store while the buffer is full or a flush is in progress. flush_req/flush_done let the testbench or system force the buffer empty.

---
 rtl/dmem_write_buffer.sv | 114 +++++++++++
 tb/tb_dmem_write_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_buffer.sv
// Data memory with a FIFO write buffer that drains at a throttled rate into a word array.
// Loads forward from the youngest matching buffered store; flush_req forces the buffer empty.
module dmem_write_buffer #(
   parameter int unsigned DATA_SIZE    = 32,
   parameter int unsigned ADDRESS_SIZE = 32,
   parameter int unsigned MEM_DEPTH    = 256,
   parameter int unsigned WB_DEPTH     = 4,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        dm_write_enable,
   input  logic [ADDRESS_SIZE-1:0]     dm_write_address,
   input  logic [DATA_SIZE-1:0]        dm_write_data,
   input  logic [ADDRESS_SIZE-1:0]     dm_read_address,
   output logic [DATA_SIZE-1:0]        dm_read_data,
   output logic                        dm_stall,
   input  logic                        flush_req,
   output logic                        flush_done,
   output logic [$clog2(WB_DEPTH):0]   wb_count
);

   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
   localparam int unsigned PTR_W = $clog2(WB_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned DC_W  = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

   state_t               state, state_nxt;
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [DC_W-1:0]      drain_cnt;
   logic [CNT_W-1:0]     count_nxt;
   logic                 push, pop;
   logic [IDX_W-1:0]     wr_idx, rd_idx;
   logic [IDX_W-1:0]     wb_idx  [WB_DEPTH];
   logic [DATA_SIZE-1:0] wb_data [WB_DEPTH];
   logic [DATA_SIZE-1:0] mem     [MEM_DEPTH];
   logic                 unused_addr_bits;

   // Word index; byte offset and high bits alias away
   assign wr_idx = dm_write_address[IDX_W+1:2];
   assign rd_idx = dm_read_address[IDX_W+1:2];
   assign unused_addr_bits = ^{dm_write_address[ADDRESS_SIZE-1:IDX_W+2], dm_write_address[1:0],
                               dm_read_address[ADDRESS_SIZE-1:IDX_W+2], dm_read_address[1:0]};

   // Conservative stall: a same-cycle drain never frees a slot for this cycle's store
   assign dm_stall  = dm_write_enable & ((wb_count == CNT_W'(WB_DEPTH)) | (state != IDLE));
   assign push      = dm_write_enable & ~dm_stall;
   assign pop       = (wb_count != '0) & (drain_cnt == DC_W'(DRAIN_CYCLES - 1));
   assign count_nxt = wb_count + CNT_W'(push) - CNT_W'(pop);
   assign flush_done = (state == DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         wb_count  <= '0;
         drain_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         wb_count <= count_nxt;
         if (pop || (wb_count == '0))
            drain_cnt <= '0;
         else
            drain_cnt <= drain_cnt + DC_W'(1);
      end
   end

   // Buffer payload needs no reset: only slots below wb_count are ever read
   always_ff @(posedge clock) begin
      if (push) begin
         wb_idx[wr_ptr]  <= wr_idx;
         wb_data[wr_ptr] <= dm_write_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (pop) begin
         mem[wb_idx[rd_ptr]] <= wb_data[rd_ptr];
      end
   end

   // Walk oldest to youngest so the youngest match overrides
   always_comb begin
      logic [PTR_W-1:0] slot;
      slot         = '0;
      dm_read_data = mem[rd_idx];
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
         slot = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < wb_count) && (wb_idx[slot] == rd_idx))
            dm_read_data = wb_data[slot];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (flush_req) state_nxt = FLUSH;
         FLUSH:   if (count_nxt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed and randomized bench for dmem_write_buffer against a queue-based reference model.
module tb_dmem_write_buffer;

   localparam int unsigned MEM_DEPTH    = 256;
   localparam int unsigned WB_DEPTH     = 4;
   localparam int unsigned DRAIN_CYCLES = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        dm_write_enable;
   logic [31:0] dm_write_address;
   logic [31:0] dm_write_data;
   logic [31:0] dm_read_address;
   logic [31:0] dm_read_data;
   logic        dm_stall;
   logic        flush_req;
   logic        flush_done;
   logic [2:0]  wb_count;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: pending stores in program order, backing words, drain age, flush phase
   int unsigned q_idx[$];
   logic [31:0] q_dat[$];
   logic [31:0] mem_m [MEM_DEPTH];
   int unsigned drain_age;
   int unsigned fmode;

   dmem_write_buffer #(
      .DATA_SIZE(32), .ADDRESS_SIZE(32), .MEM_DEPTH(MEM_DEPTH),
      .WB_DEPTH(WB_DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .dm_write_enable(dm_write_enable), .dm_write_address(dm_write_address),
      .dm_write_data(dm_write_data), .dm_read_address(dm_read_address),
      .dm_read_data(dm_read_data), .dm_stall(dm_stall),
      .flush_req(flush_req), .flush_done(flush_done), .wb_count(wb_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned word_of(input logic [31:0] a);
      return (a >> 2) % MEM_DEPTH;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] ra);
      logic [31:0] r;
      r = mem_m[word_of(ra)];
      for (int i = 0; i < q_idx.size(); i++)
         if (q_idx[i] == word_of(ra)) r = q_dat[i];
      return r;
   endfunction

   task automatic model_reset();
      q_idx.delete();
      q_dat.delete();
      for (int i = 0; i < MEM_DEPTH; i++) mem_m[i] = '0;
      drain_age = 0;
      fmode = 0;
   endtask

   task automatic model_edge(input logic push, input logic [31:0] wa, input logic [31:0] wd,
                             input logic fr);
      if (q_idx.size() > 0) begin
         if (drain_age == DRAIN_CYCLES - 1) begin
            mem_m[q_idx[0]] = q_dat[0];
            void'(q_idx.pop_front());
            void'(q_dat.pop_front());
            drain_age = 0;
         end else begin
            drain_age++;
         end
      end else begin
         drain_age = 0;
      end
      if (push) begin
         q_idx.push_back(word_of(wa));
         q_dat.push_back(wd);
      end
      case (fmode)
         0: if (fr) fmode = 1;
         1: if (q_idx.size() == 0) fmode = 2;
         default: fmode = 0;
      endcase
   endtask

   // One clock cycle: drive, check every output against the model, clock the model
   task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ra, input logic fr);
      logic exp_stall;
      dm_write_enable  = we;
      dm_write_address = wa;
      dm_write_data    = wd;
      dm_read_address  = ra;
      flush_req        = fr;
      #3;
      exp_stall = we && ((q_idx.size() == WB_DEPTH) || (fmode != 0));
      chk("wb_count", 32'(wb_count), 32'(q_idx.size()));
      chk("dm_stall", 32'(dm_stall), 32'(exp_stall));
      chk("dm_read_data", dm_read_data, model_read(ra));
      chk("flush_done", 32'(flush_done), 32'(fmode == 2));
      @(posedge clock);
      model_edge(we && !exp_stall, wa, wd, fr);
      #1;
   endtask

   task automatic peek(input string tag, input logic [31:0] ra, input logic [31:0] exp_data,
                       input int exp_cnt);
      dm_write_enable = 1'b0;
      flush_req       = 1'b0;
      dm_read_address = ra;
      #1;
      chk({tag, "_data"}, dm_read_data, exp_data);
      chk({tag, "_count"}, 32'(wb_count), 32'(exp_cnt));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      logic        seen;
      logic        r_we, r_fr;
      logic [31:0] r_wa, r_wd, r_ra;

      reset_n = 1'b0;
      dm_write_enable = 1'b0; dm_write_address = '0; dm_write_data = '0;
      dm_read_address = 32'h10; flush_req = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_count", 32'(wb_count), 32'h0);
      chk("rst_flush_done", 32'(flush_done), 32'h0);
      chk("rst_read", dm_read_data, 32'h0);
      chk("rst_stall", 32'(dm_stall), 32'h0);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Basic store, forwarding for four cycles, then array hit
      step(1'b1, 32'h10, 32'hAAAA5555, 32'h10, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         peek("basic_fwd", 32'h10, 32'hAAAA5555, 1);
         step(1'b0, 32'h0, 32'h0, 32'h10, 1'b0);
      end
      peek("basic_array", 32'h10, 32'hAAAA5555, 0);
      peek("basic_other", 32'h14, 32'h0, 0);
      step(1'b0, 32'h0, 32'h0, 32'h14, 1'b0);

      // Fill the buffer, observe the stall, then the held store gets in
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'(i * 4), 32'h100 + 32'(i), 32'h0, 1'b0);
      dm_write_enable = 1'b1; dm_write_address = 32'h20; dm_write_data = 32'h104;
      #1;
      chk("full_stall", 32'(dm_stall), 32'h1);
      chk("full_count", 32'(wb_count), 32'h4);
      step(1'b1, 32'h20, 32'h104, 32'h0, 1'b0);
      dm_write_enable = 1'b1;
      #1;
      chk("full_accept", 32'(dm_stall), 32'h0);
      step(1'b1, 32'h20, 32'h104, 32'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (flush_done === 1'b1) begin seen = 1'b1; break; end
         step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      end
      chk("full_flush_seen", 32'(seen), 32'h1);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      peek("full_w0", 32'h0, 32'h100, 0);  idle(1);
      peek("full_w1", 32'h4, 32'h101, 0);  idle(1);
      peek("full_w2", 32'h8, 32'h102, 0);  idle(1);
      peek("full_w3", 32'hC, 32'h103, 0);  idle(1);
      peek("full_w4", 32'h20, 32'h104, 0); idle(1);

      // Same-index stores: youngest wins before and after drain
      step(1'b1, 32'h40, 32'h1, 32'h40, 1'b0);
      step(1'b1, 32'h40, 32'h2, 32'h40, 1'b0);
      peek("same_fwd", 32'h40, 32'h2, 2);
      idle(10);
      peek("same_array", 32'h40, 32'h2, 0);

      // A store is not visible to a load in its own cycle
      dm_write_enable = 1'b1; dm_write_address = 32'h80; dm_write_data = 32'h7;
      dm_read_address = 32'h80;
      #1;
      chk("same_cycle_read", dm_read_data, 32'h0);
      step(1'b1, 32'h80, 32'h7, 32'h80, 1'b0);
      peek("next_cycle_read", 32'h80, 32'h7, 1);
      idle(6);

      // Flush with three entries: stores stall, single-cycle done pulse
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h30 + 32'(i * 4), 32'hC0 + 32'(i), 32'h30, 1'b0);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      dm_write_enable = 1'b1; dm_write_address = 32'h50; dm_write_data = 32'h55;
      #1;
      chk("flush_stall", 32'(dm_stall), 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (flush_done === 1'b1) begin seen = 1'b1; break; end
         step(1'b1, 32'h50, 32'h55, 32'h34, 1'b0);
      end
      chk("flush_seen", 32'(seen), 32'h1);
      chk("flush_done_count", 32'(wb_count), 32'h0);
      step(1'b1, 32'h50, 32'h55, 32'h38, 1'b0);
      dm_write_enable = 1'b1;
      #1;
      chk("flush_pulse_end", 32'(flush_done), 32'h0);
      chk("flush_resume", 32'(dm_stall), 32'h0);
      step(1'b1, 32'h50, 32'h55, 32'h50, 1'b0);
      idle(6);

      // Empty flush: done two cycles after the request is sampled
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      #1;
      chk("empty_flush_c1", 32'(flush_done), 32'h0);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("empty_flush_c2", 32'(flush_done), 32'h1);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

      // Reset during drain and flush: buffer and array cleared, no done pulse
      step(1'b1, 32'h60, 32'h61, 32'h0, 1'b0);
      step(1'b1, 32'h64, 32'h65, 32'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      dm_write_enable = 1'b0; flush_req = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_count", 32'(wb_count), 32'h0);
      model_reset();
      @(negedge clock);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock);
      #1;
      peek("midrst_r10", 32'h10, 32'h0, 0); idle(1);
      peek("midrst_r40", 32'h40, 32'h0, 0); idle(1);
      peek("midrst_r60", 32'h60, 32'h0, 0); idle(1);
      peek("midrst_r64", 32'h64, 32'h0, 0);
      idle(4);

      // Randomized traffic over a small aliased index set
      for (int n = 0; n < 400; n++) begin
         r_we = 1'($urandom_range(0, 1));
         r_wa = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         r_wd = $urandom();
         r_ra = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         r_fr = ($urandom_range(0, 19) == 0);
         step(r_we, r_wa, r_wd, r_ra, r_fr);
      end
      idle(20);
      for (int i = 0; i < 8; i++)
         step(1'b0, 32'h0, 32'h0, 32'(i * 4), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
